// File: rtl/rx_pol_ctrl.sv
// rx_pol_ctrl: sequencer for the RX polarity adjuster.
// Walks IDLE -> SETTLE -> ACQUIRE -> LOCKED and retries through BACKOFF
// after each acquisition timeout. After MAX_RETRY retries it parks in FAIL
// until i_restart. All outputs come straight from flops, so every output
// reflects the state and inputs sampled at the previous clock edge.
module rx_pol_ctrl #(
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned ACQ_TIMEOUT = 4096,
  parameter int unsigned BACKOFF_CYC = 256,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 13
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_restart,
  input  logic       i_cont_mode,
  input  logic       i_force_en,
  input  logic       i_force_val,
  input  logic       i_pol_done,
  input  logic       i_pol_status,
  output logic       o_pol_adj_en,
  output logic       o_pol_cont_adj,
  output logic       o_pol_ow,
  output logic       o_pol_ow_val,
  output logic       o_locked,
  output logic       o_fail,
  output logic       o_lock_lost,
  output logic       o_pol_flip,
  output logic       o_lock_pol,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
);

  // State encoding is visible on o_state, so the values are fixed.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_ACQUIRE = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  // Terminal counts for the timed states.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST     = CNT_W'(ACQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRY);

  // Sequencer state.
  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       retry_reg;
  logic [3:0]       retry_next;
  logic             lock_pol_reg;
  logic             lock_pol_next;

  // Registered outputs.
  logic             adj_en_reg;
  logic             cont_adj_reg;
  logic             ow_reg;
  logic             ow_val_reg;
  logic             locked_reg;
  logic             fail_reg;
  logic             lock_lost_reg;
  logic             flip_reg;

  // Next-cycle values of the pulse and decode outputs.
  logic             adj_en_next;
  logic             lock_lost_next;
  logic             flip_next;
  logic             timed_out;

  assign timed_out = (cnt_reg == ACQ_LAST);

  // Next-state, counter, retry and latched-polarity logic.
  always_comb begin
    state_next     = state_reg;
    retry_next     = retry_reg;
    lock_pol_next  = lock_pol_reg;
    lock_lost_next = 1'b0;
    flip_next      = 1'b0;

    if (!i_enable) begin
      // Dropping enable abandons the sequence from any state.
      state_next    = ST_IDLE;
      retry_next    = 4'd0;
      lock_pol_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            state_next = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          // A lock reported on the timeout cycle still counts as a lock.
          if (i_pol_done) begin
            state_next    = ST_LOCKED;
            lock_pol_next = i_pol_status;
            retry_next    = 4'd0;
          end else if (timed_out) begin
            if (retry_reg == RETRY_LAST) begin
              state_next = ST_FAIL;
            end else begin
              state_next = ST_BACKOFF;
              retry_next = retry_reg + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (!i_pol_done) begin
            state_next     = ST_ACQUIRE;
            lock_lost_next = 1'b1;
          end else if (i_pol_status != lock_pol_reg) begin
            // Flip pulse and the new latched polarity appear together.
            flip_next     = 1'b1;
            lock_pol_next = i_pol_status;
          end
        end
        ST_BACKOFF: begin
          if (cnt_reg == BACKOFF_LAST) begin
            state_next = ST_ACQUIRE;
          end
        end
        ST_FAIL: begin
          if (i_restart) begin
            state_next = ST_SETTLE;
            retry_next = 4'd0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          retry_next = 4'd0;
        end
      endcase
    end

    // Counter restarts on every state entry. States that can dwell
    // indefinitely (IDLE, LOCKED, FAIL) saturate instead of wrapping.
    if (!i_enable || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    adj_en_next = (state_next == ST_ACQUIRE) || (state_next == ST_LOCKED);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      retry_reg     <= 4'd0;
      lock_pol_reg  <= 1'b0;
      adj_en_reg    <= 1'b0;
      cont_adj_reg  <= 1'b0;
      ow_reg        <= 1'b0;
      ow_val_reg    <= 1'b0;
      locked_reg    <= 1'b0;
      fail_reg      <= 1'b0;
      lock_lost_reg <= 1'b0;
      flip_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      lock_pol_reg  <= lock_pol_next;
      adj_en_reg    <= adj_en_next;
      cont_adj_reg  <= i_cont_mode & adj_en_next;
      ow_reg        <= i_force_en;
      ow_val_reg    <= i_force_val;
      locked_reg    <= (state_next == ST_LOCKED);
      fail_reg      <= (state_next == ST_FAIL);
      lock_lost_reg <= lock_lost_next;
      flip_reg      <= flip_next;
    end
  end

  assign o_pol_adj_en   = adj_en_reg;
  assign o_pol_cont_adj = cont_adj_reg;
  assign o_pol_ow       = ow_reg;
  assign o_pol_ow_val   = ow_val_reg;
  assign o_locked       = locked_reg;
  assign o_fail         = fail_reg;
  assign o_lock_lost    = lock_lost_reg;
  assign o_pol_flip     = flip_reg;
  assign o_lock_pol     = lock_pol_reg;
  assign o_retry_cnt    = retry_reg;
  assign o_state        = state_reg;

endmodule

// File: tb/tb_rx_pol_ctrl.sv
// tb_rx_pol_ctrl: directed table-driven bench for rx_pol_ctrl, plus
// hand-written sequences for the retry/FAIL path, restart, reset while
// locked and the done-on-timeout corner.
module tb_rx_pol_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n, i_enable, i_restart, i_cont_mode;
  logic       i_force_en, i_force_val, i_pol_done, i_pol_status;
  logic       o_pol_adj_en, o_pol_cont_adj, o_pol_ow, o_pol_ow_val;
  logic       o_locked, o_fail, o_lock_lost, o_pol_flip, o_lock_pol;
  logic [3:0] o_retry_cnt;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  rx_pol_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_restart      (i_restart),
    .i_cont_mode    (i_cont_mode),
    .i_force_en     (i_force_en),
    .i_force_val    (i_force_val),
    .i_pol_done     (i_pol_done),
    .i_pol_status   (i_pol_status),
    .o_pol_adj_en   (o_pol_adj_en),
    .o_pol_cont_adj (o_pol_cont_adj),
    .o_pol_ow       (o_pol_ow),
    .o_pol_ow_val   (o_pol_ow_val),
    .o_locked       (o_locked),
    .o_fail         (o_fail),
    .o_lock_lost    (o_lock_lost),
    .o_pol_flip     (o_pol_flip),
    .o_lock_pol     (o_lock_pol),
    .o_retry_cnt    (o_retry_cnt),
    .o_state        (o_state)
  );

  typedef struct packed {
    logic rst_n, enable, restart, cont, force_en, force_val, done, status;
  } in_t;

  typedef struct packed {
    logic       adj_en, cont_adj, ow, ow_val, locked, fail, lost, flip, lock_pol;
    logic [3:0] retry;
    logic [2:0] state;
  } out_t;

  typedef struct {
    in_t  in;
    int   ncyc;
    out_t exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t mi(logic rst_n, logic en, logic rs, logic cm,
                             logic fe, logic fv, logic dn, logic st);
    in_t r;
    r.rst_n = rst_n; r.enable = en; r.restart = rs; r.cont = cm;
    r.force_en = fe; r.force_val = fv; r.done = dn; r.status = st;
    return r;
  endfunction

  function automatic out_t mo(logic adj, logic ca, logic ow, logic owv,
                              logic lk, logic fl, logic lost, logic flip,
                              logic lp, logic [3:0] rt, logic [2:0] st);
    out_t r;
    r.adj_en = adj; r.cont_adj = ca; r.ow = ow; r.ow_val = owv;
    r.locked = lk; r.fail = fl; r.lost = lost; r.flip = flip;
    r.lock_pol = lp; r.retry = rt; r.state = st;
    return r;
  endfunction

  task automatic apply(in_t v);
    i_rst_n      = v.rst_n;
    i_enable     = v.enable;
    i_restart    = v.restart;
    i_cont_mode  = v.cont;
    i_force_en   = v.force_en;
    i_force_val  = v.force_val;
    i_pol_done   = v.done;
    i_pol_status = v.status;
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, string field, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, field, act, req);
    end
  endtask

  task automatic check_out(string tag, out_t e);
    chk1(tag, "adj_en",    32'(o_pol_adj_en),   32'(e.adj_en));
    chk1(tag, "cont_adj",  32'(o_pol_cont_adj), 32'(e.cont_adj));
    chk1(tag, "ow",        32'(o_pol_ow),       32'(e.ow));
    chk1(tag, "ow_val",    32'(o_pol_ow_val),   32'(e.ow_val));
    chk1(tag, "locked",    32'(o_locked),       32'(e.locked));
    chk1(tag, "fail",      32'(o_fail),         32'(e.fail));
    chk1(tag, "lock_lost", 32'(o_lock_lost),    32'(e.lost));
    chk1(tag, "pol_flip",  32'(o_pol_flip),     32'(e.flip));
    chk1(tag, "lock_pol",  32'(o_lock_pol),     32'(e.lock_pol));
    chk1(tag, "retry_cnt", 32'(o_retry_cnt),    32'(e.retry));
    chk1(tag, "state",     32'(o_state),        32'(e.state));
    $display("txn %-12s state=%0d adj=%0b lk=%0b fl=%0b retry=%0d lp=%0b",
             tag, o_state, o_pol_adj_en, o_locked, o_fail, o_retry_cnt, o_lock_pol);
  endtask

  task automatic run(string tag, in_t i, int n, out_t e);
    apply(i);
    step(n);
    check_out(tag, e);
  endtask

  // Hard stop in case the design never advances.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t run_in, dn_in;

    //            rst en rs cm fe fv dn st         adj ca ow owv lk fl lost flip lp rt st
    vec[0]  = '{mi(0,0,0,0,0,0,0,0),    2, mo(0,0,0,0,0,0,0,0,0,0,0)}; // reset
    vec[1]  = '{mi(1,0,0,0,1,1,0,0),    1, mo(0,0,1,1,0,0,0,0,0,0,0)}; // override in IDLE
    vec[2]  = '{mi(1,1,0,1,0,0,0,0),    1, mo(0,0,0,0,0,0,0,0,0,0,1)}; // enable -> SETTLE
    vec[3]  = '{mi(1,1,0,1,0,0,0,0),   62, mo(0,0,0,0,0,0,0,0,0,0,1)};
    vec[4]  = '{mi(1,1,0,1,0,0,0,0),    1, mo(0,0,0,0,0,0,0,0,0,0,1)}; // last SETTLE cycle
    vec[5]  = '{mi(1,1,0,1,0,0,0,0),    1, mo(1,1,0,0,0,0,0,0,0,0,2)}; // ACQUIRE, 64 after enable
    vec[6]  = '{mi(1,1,0,1,0,0,0,0),   10, mo(1,1,0,0,0,0,0,0,0,0,2)};
    vec[7]  = '{mi(1,1,0,1,0,0,1,0),    1, mo(1,1,0,0,1,0,0,0,0,0,3)}; // done at cycle 10
    vec[8]  = '{mi(1,1,0,1,0,0,1,1),    1, mo(1,1,0,0,1,0,0,1,1,0,3)}; // flip pulse
    vec[9]  = '{mi(1,1,0,1,0,0,1,1),    1, mo(1,1,0,0,1,0,0,0,1,0,3)}; // flip gone
    vec[10] = '{mi(1,1,0,1,0,0,0,1),    1, mo(1,1,0,0,0,0,1,0,1,0,2)}; // lock lost
    vec[11] = '{mi(1,1,0,1,0,0,0,1),    1, mo(1,1,0,0,0,0,0,0,1,0,2)};
    vec[12] = '{mi(1,0,0,1,1,0,0,1),    1, mo(0,0,1,0,0,0,0,0,0,0,0)}; // disable mid-ACQUIRE
    vec[13] = '{mi(1,1,0,0,0,0,0,0),   65, mo(1,0,0,0,0,0,0,0,0,0,2)};
    vec[14] = '{mi(1,1,0,0,0,0,0,0), 4096, mo(0,0,0,0,0,0,0,0,0,1,4)}; // first timeout
    vec[15] = '{mi(1,1,0,0,0,0,0,0),   10, mo(0,0,0,0,0,0,0,0,0,1,4)};
    vec[16] = '{mi(1,0,0,0,0,0,0,0),    1, mo(0,0,0,0,0,0,0,0,0,0,0)}; // disable mid-BACKOFF
    vec[17] = '{mi(1,0,1,0,0,0,0,0),    1, mo(0,0,0,0,0,0,0,0,0,0,0)}; // restart ignored in IDLE

    apply(vec[0].in);
    for (int v = 0; v < NVEC; v++) begin
      run($sformatf("vec%0d", v), vec[v].in, vec[v].ncyc, vec[v].exp);
    end

    // Retries exhausted: 64 + 4*4096 + 3*256 edges after enable -> FAIL.
    run_in = mi(1,1,0,0,0,0,0,0);
    run("f_acq0",   run_in,   65, mo(1,0,0,0,0,0,0,0,0,0,2));
    run("f_bo1",    run_in, 4096, mo(0,0,0,0,0,0,0,0,0,1,4));
    run("f_acq1",   run_in,  256, mo(1,0,0,0,0,0,0,0,0,1,2));
    run("f_bo2",    run_in, 4096, mo(0,0,0,0,0,0,0,0,0,2,4));
    run("f_acq2",   run_in,  256, mo(1,0,0,0,0,0,0,0,0,2,2));
    run("f_bo3",    run_in, 4096, mo(0,0,0,0,0,0,0,0,0,3,4));
    run("f_acq3",   run_in,  256, mo(1,0,0,0,0,0,0,0,0,3,2));
    run("f_acq3e",  run_in, 4095, mo(1,0,0,0,0,0,0,0,0,3,2));
    run("f_fail",   run_in,    1, mo(0,0,0,0,0,1,0,0,0,3,5));
    run("f_hold",   run_in,    3, mo(0,0,0,0,0,1,0,0,0,3,5));

    // Restart out of FAIL, then lock on the first ACQUIRE cycle.
    run("r_pulse",  mi(1,1,1,0,0,0,0,0),  1, mo(0,0,0,0,0,0,0,0,0,0,1));
    run("r_settle", run_in,              63, mo(0,0,0,0,0,0,0,0,0,0,1));
    run("r_acq",    run_in,               1, mo(1,0,0,0,0,0,0,0,0,0,2));
    run("r_lock",   mi(1,1,0,0,0,0,1,1),  1, mo(1,0,0,0,1,0,0,0,1,0,3));

    // Reset while LOCKED clears every output, override included.
    run("rst_lock", mi(0,1,0,1,1,1,1,1),  1, mo(0,0,0,0,0,0,0,0,0,0,0));

    // Done arriving on the timeout cycle wins over the timeout.
    run("s_acq",    run_in,              65, mo(1,0,0,0,0,0,0,0,0,0,2));
    run("s_wait",   run_in,            4094, mo(1,0,0,0,0,0,0,0,0,0,2));
    run("s_rsign",  mi(1,1,1,0,0,0,0,0),  1, mo(1,0,0,0,0,0,0,0,0,0,2));
    dn_in = mi(1,1,0,0,0,0,1,0);
    run("s_lock",   dn_in,                1, mo(1,0,0,0,1,0,0,0,0,0,3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
